// File: rtl/card_pkg.sv
// Card types and helpers shared by the shoe, hand and display logic.
package card_pkg;

   localparam int DECK_CARDS     = 52;
   localparam int RANKS_PER_SUIT = 13;

   typedef logic [1:0] suit_t;
   typedef logic [3:0] rank_t;

   typedef struct packed {
      suit_t suit;
      rank_t rank;
   } card_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEARCH,
      S_DEAL,
      S_EMPTY
   } shoe_state_t;

   // Slot 0..51 -> {suit, rank 1..13}; each suit is a 13-slot band, so a compare chain replaces the divide.
   function automatic card_t idx_to_card(input logic [5:0] idx);
      card_t card;
      if (idx < 6'(RANKS_PER_SUIT)) begin
         card.suit = 2'd0;
         card.rank = rank_t'(idx + 6'd1);
      end else if (idx < 6'(2 * RANKS_PER_SUIT)) begin
         card.suit = 2'd1;
         card.rank = rank_t'(idx - 6'(RANKS_PER_SUIT - 1));
      end else if (idx < 6'(3 * RANKS_PER_SUIT)) begin
         card.suit = 2'd2;
         card.rank = rank_t'(idx - 6'(2 * RANKS_PER_SUIT - 1));
      end else begin
         card.suit = 2'd3;
         card.rank = rank_t'(idx - 6'(3 * RANKS_PER_SUIT - 1));
      end
      return card;
   endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11); loads SEED on reset.
module lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        i_clk,
   input  logic        i_reset,
   output logic [15:0] o_value
);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_value <= SEED;
      end else begin
         o_value <= {o_value[14:0], o_value[15] ^ o_value[13] ^ o_value[12] ^ o_value[10]};
      end
   end

endmodule

// File: rtl/card_shoe.sv
// 52-card shoe dealing without replacement from a dealt-card mask, using an LFSR start slot.
// Build option CARD_SHOE_AUTO_RESHUFFLE_EN: a draw while empty reshuffles implicitly, then deals.
module card_shoe
   import card_pkg::*;
#(
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_drawReq,
   input  logic       i_shuffle,
   output logic       o_ready,
   output logic       o_cardValid,
   output logic [5:0] o_card,
   output logic [5:0] o_remaining,
   output logic       o_empty
);

   localparam logic [5:0] DECK     = 6'(DECK_CARDS);
   localparam logic [5:0] LAST_IDX = 6'(DECK_CARDS - 1);

`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
   localparam bit AUTO_RESHUFFLE = 1'b1;
`else
   localparam bit AUTO_RESHUFFLE = 1'b0;
`endif

   if (LFSR_SEED == 16'd0) begin : g_seed_check
      $error("card_shoe: LFSR_SEED must be nonzero");
   end

   shoe_state_t state;
   logic [DECK_CARDS-1:0] mask;
   logic [5:0]  idx;
   card_t       card;
   logic [15:0] lfsr_value;
   logic [9:0]  unused_lfsr_bits;
   logic [5:0]  start_idx;
   logic        ready_idle;
   logic        take;

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .o_value (lfsr_value)
   );

   assign unused_lfsr_bits = lfsr_value[15:6];
   assign start_idx  = (lfsr_value[5:0] >= DECK) ? lfsr_value[5:0] - DECK : lfsr_value[5:0];
   assign ready_idle = (o_remaining != 6'd0) || AUTO_RESHUFFLE;
   assign o_card     = card;

`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
   // Set for the one cycle between an implicit reshuffle and its search.
   logic reload;
   assign take = (i_drawReq && o_ready) || reload;
`else
   assign take = i_drawReq && o_ready;
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state       <= S_IDLE;
         // NOTE: the mask is a flop vector rather than a RAM, so it can be cleared in a single cycle.
         mask        <= '0;
         idx         <= '0;
         card        <= '0;
         o_cardValid <= 1'b0;
         o_remaining <= DECK;
         o_empty     <= 1'b0;
         o_ready     <= 1'b1;
`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
         reload      <= 1'b0;
`endif
      end else if (i_shuffle) begin
         // Aborts any search in flight without a pulse; the last card stays on o_card.
         state       <= S_IDLE;
         mask        <= '0;
         o_cardValid <= 1'b0;
         o_remaining <= DECK;
         o_empty     <= 1'b0;
         o_ready     <= 1'b0;
`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
         reload      <= 1'b0;
`endif
      end else begin
         // NOTE: defaulting valid low every cycle keeps it a single-cycle pulse whatever the state.
         o_cardValid <= 1'b0;
         unique case (state)
            S_IDLE, S_EMPTY: begin
               if (take && o_remaining != 6'd0) begin
                  idx     <= start_idx;
                  o_ready <= 1'b0;
                  state   <= S_SEARCH;
`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
                  reload  <= 1'b0;
`endif
               end
`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
               else if (take) begin
                  mask        <= '0;
                  o_remaining <= DECK;
                  o_empty     <= 1'b0;
                  o_ready     <= 1'b0;
                  reload      <= 1'b1;
                  state       <= S_IDLE;
               end
`endif
               else begin
                  o_ready <= ready_idle;
                  if (o_remaining == 6'd0) begin
                     state <= S_EMPTY;
                  end
               end
            end

            S_SEARCH: begin
               if (!mask[idx]) begin
                  mask[idx]   <= 1'b1;
                  o_remaining <= o_remaining - 6'd1;
                  o_empty     <= (o_remaining == 6'd1);
                  card        <= idx_to_card(idx);
                  o_cardValid <= 1'b1;
                  state       <= S_DEAL;
               end else begin
                  idx <= (idx == LAST_IDX) ? 6'd0 : idx + 6'd1;
               end
            end

            S_DEAL: begin
               o_ready <= ready_idle;
               state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule
